latch_wr_arbiter: RTL and testbench

LATCH_WR_ARBITER -- requirements
Module: latch_wr_arbiter

---
 rtl/latch_arb_pkg.sv | 17 +
 rtl/latch_wr_arbiter_rr_pick.sv | 27 ++
 rtl/latch_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_latch_wr_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/latch_arb_pkg.sv
// Shared FSM state encoding and default sizing for the latch-bank write arbiter.
package latch_arb_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_N_LAT    = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_OPEN_CYC = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    OPEN,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/latch_wr_arbiter_rr_pick.sv
// Round-robin picker: first set req bit searching upward from ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_wr_arbiter.sv
// Arbitrates requesters onto a shared bank of level-sensitive latches with a
// glitch-free SETUP / OPEN / HOLD write sequence; all outputs come from flops.
module latch_wr_arbiter
  import latch_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int N_LAT    = DEF_N_LAT,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OPEN_CYC = DEF_OPEN_CYC
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*WIDTH-1:0]       req_data,
  input  logic [N_REQ*((N_LAT > 1) ? $clog2(N_LAT) : 1)-1:0] req_addr,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             ack,
  output logic [WIDTH-1:0]             lat_d,
  output logic [N_LAT-1:0]             lat_en,
  output logic                         busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = (N_LAT > 1) ? $clog2(N_LAT) : 1;
  localparam logic [3:0] OPEN_LD = 4'(OPEN_CYC - 1);

  state_t            state, state_nx;
  logic [PW-1:0]     ptr;
  logic [3:0]        cnt;
  logic [N_REQ-1:0]  pick;
  logic              pick_vld;
  logic [WIDTH-1:0]  data_sel;
  logic [AW-1:0]     addr_sel;
  logic [AW-1:0]     addr_q;
  logic [N_LAT-1:0]  addr_oh;

  function automatic int onehot_idx(input logic [N_REQ-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < N_REQ; i++)
      if (oh[i]) r = i;
    return r;
  endfunction

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_vld)
  );

  always_comb begin
    data_sel = '0;
    addr_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        data_sel = data_sel | req_data[i*WIDTH +: WIDTH];
        addr_sel = addr_sel | req_addr[i*AW +: AW];
      end
    end
  end

  always_comb begin
    addr_oh         = '0;
    addr_oh[addr_q] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = SETUP;
      SETUP:   state_nx = OPEN;
      OPEN:    if (cnt == 4'd0) state_nx = HOLD;
      HOLD:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Address is only consumed while a transaction is in flight, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && pick_vld) addr_q <= addr_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      cnt    <= '0;
      gnt    <= '0;
      ack    <= '0;
      lat_en <= '0;
      lat_d  <= '0;
      busy   <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt   <= pick;
            lat_d <= data_sel;
          end
        end
        SETUP: begin
          cnt    <= OPEN_LD;
          lat_en <= addr_oh;
        end
        OPEN: begin
          if (cnt == 4'd0) lat_en <= '0;
          else             cnt    <= cnt - 4'd1;
        end
        HOLD: begin
          ack <= gnt;
          ptr <= PW'((onehot_idx(gnt) + 1) % N_REQ);
        end
        DONE: begin
          ack <= '0;
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// Directed bench for latch_wr_arbiter at default parameters.
module tb_latch_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [7:0]  req_addr;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  lat_d;
  logic [3:0]  lat_en;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [3:0] prev_en = '0;
  logic [7:0] prev_d  = '0;
  logic [3:0] exp_oh;

  latch_wr_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .req_addr (req_addr),
    .gnt      (gnt),
    .ack      (ack),
    .lat_d    (lat_d),
    .lat_en   (lat_en),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [1:0] a);
    req_data[i*8 +: 8] = d;
    req_addr[i*2 +: 2] = a;
  endtask

  // Advance to the next falling edge and apply the bank-safety invariants.
  task automatic tick();
    @(negedge clk);
    if (lat_en != 4'd0) begin
      chk("en_onehot", 32'($countones(lat_en) <= 1), 32'd1);
      if (prev_en != 4'd0) chk("lat_d_stable", 32'(lat_d), 32'(prev_d));
    end
    prev_en = lat_en;
    prev_d  = lat_d;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    req_addr = '0;
    #2;
    chk("rst_gnt",    32'(gnt),    32'd0);
    chk("rst_ack",    32'(ack),    32'd0);
    chk("rst_lat_en", 32'(lat_en), 32'd0);
    chk("rst_lat_d",  32'(lat_d),  32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Single write: requester 0, data A5, latch 2
    set_req(0, 8'hA5, 2'd2);
    req = 4'b0001;
    tick();
    chk("sw_gnt",       32'(gnt),    32'h1);
    chk("sw_busy",      32'(busy),   32'd1);
    chk("sw_setup_en",  32'(lat_en), 32'h0);
    chk("sw_setup_d",   32'(lat_d),  32'hA5);
    tick();
    chk("sw_open1_en",  32'(lat_en), 32'h4);
    chk("sw_open1_ack", 32'(ack),    32'h0);
    tick();
    chk("sw_open2_en",  32'(lat_en), 32'h4);
    tick();
    chk("sw_hold_en",   32'(lat_en), 32'h0);
    chk("sw_hold_d",    32'(lat_d),  32'hA5);
    req = 4'b0000;
    tick();
    chk("sw_ack",       32'(ack),    32'h1);
    chk("sw_done_busy", 32'(busy),   32'd1);
    tick();
    chk("sw_ack_clr",   32'(ack),    32'h0);
    chk("sw_idle_busy", 32'(busy),   32'd0);
    chk("sw_idle_gnt",  32'(gnt),    32'h0);

    // Data and address change after capture are ignored
    set_req(0, 8'h11, 2'd1);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    chk("dc_open_en", 32'(lat_en), 32'h2);
    set_req(0, 8'h22, 2'd3);
    tick();
    chk("dc_lat_d",   32'(lat_d),  32'h11);
    chk("dc_en_keep", 32'(lat_en), 32'h2);
    tick();
    chk("dc_hold_d",  32'(lat_d),  32'h11);
    tick();
    chk("dc_ack",     32'(ack),    32'h1);
    tick();

    // Early drop in SETUP still completes
    set_req(0, 8'h3C, 2'd0);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    chk("ed_gnt", 32'(gnt), 32'h1);
    tick();
    tick();
    tick();
    tick();
    chk("ed_ack", 32'(ack), 32'h1);
    tick();
    chk("ed_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("ed_no_retrig", 32'(busy), 32'd0);

    // Pointer now 1: requesters 0 and 2 pending, 2 wins
    set_req(2, 8'h77, 2'd3);
    req = 4'b0101;
    tick();
    req = 4'b0000;
    chk("rr_gnt", 32'(gnt), 32'h4);
    tick();
    chk("rr_en", 32'(lat_en), 32'h8);
    tick();
    tick();
    tick();
    chk("rr_ack", 32'(ack), 32'h4);
    tick();

    // Reset mid-OPEN
    set_req(0, 8'h5A, 2'd0);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    chk("ro_open_en", 32'(lat_en), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ro_en",   32'(lat_en), 32'h0);
    chk("ro_ack",  32'(ack),    32'h0);
    chk("ro_gnt",  32'(gnt),    32'h0);
    chk("ro_busy", 32'(busy),   32'd0);
    chk("ro_d",    32'(lat_d),  32'h0);
    chk("ro_ptr",  32'(dut.ptr), 32'd0);
    tick();
    tick();
    chk("ro_ack_held", 32'(ack), 32'h0);
    rst_n = 1'b1;
    set_req(1, 8'h99, 2'd1);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    chk("ro_post_gnt", 32'(gnt), 32'h2);
    tick();
    tick();
    tick();
    tick();
    chk("ro_post_ack", 32'(ack), 32'h2);
    tick();

    // Contention from reset: order 0,1,2,3,0 with acks six cycles apart
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      tick();
      chk("ct_gnt", 32'(gnt), 32'(exp_oh));
      tick();
      tick();
      tick();
      tick();
      chk("ct_ack", 32'(ack), 32'(exp_oh));
      tick();
      chk("ct_gap_busy", 32'(busy), 32'd0);
    end
    req = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
